// File: rtl/imm_encoder.sv
// Two-stage RV64 instruction encoder: stage 1 classifies and range-checks the
// immediate, stage 2 packs the instruction word. Saturating result counters.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [6:0]  in_funct7,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [1:0]  out_err,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  typedef enum logic [2:0] {TyR, TyI, TyS, TyB, TyU, TyJ, TyInv} inst_type_e;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrOp    = 2'd1;
  localparam logic [1:0] ErrRange = 2'd2;
  localparam logic [1:0] ErrAlign = 2'd3;

  inst_type_e  in_type;
  logic [1:0]  in_err;
  logic        fits12, fits13, fits21, fits32;

  logic        s1_valid;
  inst_type_e  s1_type;
  logic [1:0]  s1_err;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [2:0]  s1_funct3;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;
  logic        s1_advance;
  logic [31:0] packed_inst;

  always_comb begin
    in_type = TyInv;
    case (in_opcode)
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b0001111, 7'b1110011, 7'b1100111: in_type = TyI;
      7'b0100011:                         in_type = TyS;
      7'b1100011:                         in_type = TyB;
      7'b0110111, 7'b0010111:             in_type = TyU;
      7'b1101111:                         in_type = TyJ;
      7'b0110011, 7'b0111011:             in_type = TyR;
      default:                            in_type = TyInv;
    endcase
  end

  assign fits12 = (in_imm == {{52{in_imm[11]}}, in_imm[11:0]});
  assign fits13 = (in_imm == {{51{in_imm[12]}}, in_imm[12:0]});
  assign fits21 = (in_imm == {{43{in_imm[20]}}, in_imm[20:0]});
  assign fits32 = (in_imm == {{32{in_imm[31]}}, in_imm[31:0]});

  // Priority: invalid opcode, then misalignment, then range.
  always_comb begin
    in_err = ErrNone;
    case (in_type)
      TyInv:    in_err = ErrOp;
      TyI, TyS: in_err = fits12 ? ErrNone : ErrRange;
      TyB:      in_err = in_imm[0] ? ErrAlign : (fits13 ? ErrNone : ErrRange);
      TyJ:      in_err = in_imm[0] ? ErrAlign : (fits21 ? ErrNone : ErrRange);
      TyU:      in_err = (fits32 && (in_imm[11:0] == 12'h000)) ? ErrNone : ErrRange;
      default:  in_err = ErrNone;
    endcase
  end

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = rst_n && (!s1_valid || s1_advance);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_type   <= TyInv;
      s1_err    <= ErrNone;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_funct3 <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid  <= 1'b1;
      s1_type   <= in_type;
      s1_err    <= in_err;
      s1_opcode <= in_opcode;
      s1_rd     <= in_rd;
      s1_funct3 <= in_funct3;
      s1_rs1    <= in_rs1;
      s1_rs2    <= in_rs2;
      s1_funct7 <= in_funct7;
      s1_imm    <= in_imm[31:0];
    end else if (s1_advance) begin
      s1_valid  <= 1'b0;
    end
  end

  always_comb begin
    packed_inst = 32'h0000_0000;
    if (s1_err == ErrNone) begin
      case (s1_type)
        TyR: packed_inst = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
        TyI: packed_inst = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        TyS: packed_inst = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        TyB: packed_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                            s1_imm[4:1], s1_imm[11], s1_opcode};
        TyU: packed_inst = {s1_imm[31:12], s1_rd, s1_opcode};
        TyJ: packed_inst = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                            s1_rd, s1_opcode};
        default: packed_inst = 32'h0000_0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= ErrNone;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= packed_inst;
        out_err  <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (out_valid && out_ready) begin
      if (out_err == ErrNone) begin
        if (cnt_ok != 16'hFFFF) cnt_ok <= cnt_ok + 16'd1;
      end else begin
        if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed cases plus random traffic against a range-based
// reference model and an in-order scoreboard.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1, in_rs2;
  logic [6:0]  in_funct7;
  logic [63:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic [15:0] cnt_ok, cnt_err;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];
  logic [33:0] last_res;
  int          m_ok, m_err;
  logic        stall_prev;
  logic [33:0] stall_res;

  logic [6:0]  ops [13] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b0001111, 7'b1110011,
                            7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                            7'b1101111, 7'b0110011, 7'b0111011};
  logic [63:0] bnd [12] = '{64'h7FF, 64'hFFFF_FFFF_FFFF_F800, 64'h800, 64'hFFFF_FFFF_FFFF_F7FF,
                            64'hFFE, 64'h1000, 64'hFFFF_FFFF_FFFF_F000, 64'hFFFFE,
                            64'h10_0000, 64'h7FFF_F000, 64'h8000_0000,
                            64'hFFFF_FFFF_8000_0000};

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
  );

  always #5 clk = ~clk;

  // Reference: legality judged by numeric range of the signed immediate.
  function automatic logic [33:0] model(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] f7,
                                        input logic [63:0] imm);
    longint      s;
    logic [31:0] v;
    logic [7:0]  t;
    logic [1:0]  err;
    logic [31:0] inst;
    s = imm;
    v = imm[31:0];
    case (op)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b0001111, 7'b1110011, 7'b1100111: t = "I";
      7'b0100011: t = "S";
      7'b1100011: t = "B";
      7'b0110111, 7'b0010111: t = "U";
      7'b1101111: t = "J";
      7'b0110011, 7'b0111011: t = "R";
      default: t = "X";
    endcase
    err  = 2'd0;
    inst = 32'h0;
    if (t == "X") err = 2'd1;
    else if ((t == "B" || t == "J") && (s % 2 != 0)) err = 2'd3;
    else if ((t == "I" || t == "S") && (s < -2048 || s > 2047)) err = 2'd2;
    else if (t == "B" && (s < -4096 || s > 4095)) err = 2'd2;
    else if (t == "J" && (s < -1048576 || s > 1048575)) err = 2'd2;
    else if (t == "U" && (s < -64'sd2147483648 || s > 64'sd2147483647 || s % 4096 != 0))
      err = 2'd2;
    if (err == 2'd0) begin
      case (t)
        "R": inst = {f7, rs2, rs1, f3, rd, op};
        "I": inst = {v[11:0], rs1, f3, rd, op};
        "S": inst = {v[11:5], rs2, rs1, f3, v[4:0], op};
        "B": inst = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], op};
        "U": inst = {v[31:12], rd, op};
        default: inst = {v[20], v[10:1], v[11], v[19:12], rd, op};
      endcase
    end
    return {err, inst};
  endfunction

  function automatic logic [63:0] rand_imm();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: return {{51{r[12]}}, r[12:0]};
      1: return {{42{r[21]}}, r[21:0]};
      2: return r;
      3: return {{32{r[31]}}, r[31:12], 12'h000};
      default: return bnd[$urandom_range(0, 11)];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at each falling edge: scoreboard, stall stability, acceptance capture.
  task automatic monitor();
    logic [33:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_ok = 0;
      m_err = 0;
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev) chk("stall_hold", {out_valid, out_err, out_inst}, {1'b1, stall_res});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("result", {out_err, out_inst}, e);
        last_res = {out_err, out_inst};
        if (e[33:32] == 2'd0) begin
          if (m_ok != 65535) m_ok++;
        end else if (m_err != 65535) m_err++;
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_res  = {out_err, out_inst};
    if (in_valid && in_ready)
      exp_q.push_back(model(in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm));
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                       input logic [63:0] imm);
    in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                      input logic [63:0] imm);
    logic acc;
    int   n;
    drive(op, rd, f3, rs1, rs2, f7, imm);
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      monitor();
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int acc;
    int cyc;
    logic a;
    logic [15:0] err_before;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(7'h0, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0, 64'h0);
    m_ok = 0; m_err = 0; stall_prev = 1'b0; last_res = '0; stall_res = '0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_counts", {cnt_ok, cnt_err, out_err, out_inst}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    monitor();
    @(posedge clk);
    #1;

    // ADDI x1, x0, -1 with latency check
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("lat_first_cycle", out_valid, 0);
    monitor();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_second_cycle", out_valid, 1);
    monitor();
    @(posedge clk);
    #1;
    drain();
    chk("addi", last_res, {2'd0, 32'hFFF00093});

    send(7'b0100011, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 64'd8);
    drain();
    chk("sw", last_res, {2'd0, 32'h00512423});
    send(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'h800);
    drain();
    chk("jal", last_res, {2'd0, 32'h001000EF});
    send(7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 64'h1234_5000);
    drain();
    chk("lui", last_res, {2'd0, 32'h123452B7});
    send(7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 64'h1_0000_0000);
    drain();
    chk("lui_range", last_res, {2'd2, 32'h0});
    send(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 64'd3);
    drain();
    chk("beq_align", last_res, {2'd3, 32'h0});
    send(7'h7F, 5'd3, 3'd1, 5'd4, 5'd5, 7'd0, 64'd0);
    drain();
    chk("bad_op", last_res, {2'd1, 32'h0});
    chk("cnt_after_directed", {cnt_ok, cnt_err}, {16'd4, 16'd3});

    // Backpressure: four requests while the consumer stalls for five cycles
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(7'b0010011, 5'd2, 3'd0, 5'd3, 5'd0, 7'd0, 64'(acc + 16));
      in_valid = 1'b1;
      @(negedge clk);
      a = in_ready;
      monitor();
      @(posedge clk);
      #1;
      if (a) acc++;
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(7'b0010011, 5'd2, 3'd0, 5'd3, 5'd0, 7'd0, 64'd18);
    send(7'b0010011, 5'd2, 3'd0, 5'd3, 5'd0, 7'd0, 64'd19);
    drain();
    chk("bp_last", last_res, {2'd0, 32'h01318113});

    // Random traffic with random stalls
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 12)],
            5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom),
            rand_imm());
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("rand_cnt", {cnt_ok, cnt_err}, {16'(m_ok), 16'(m_err)});

    // Saturation of the OK counter
    err_before = cnt_err;
    out_ready = 1'b1;
    drive(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd0);
    in_valid = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 65537 && cyc < 70000) begin
      @(negedge clk);
      a = in_ready;
      monitor();
      @(posedge clk);
      #1;
      if (a) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("sat_accepts", acc, 65537);
    drain();
    chk("sat_cnt_ok", cnt_ok, 16'hFFFF);
    chk("sat_cnt_err", cnt_err, err_before);

    // Reset with both stages full
    out_ready = 1'b0;
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd1);
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd2);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_state", {cnt_ok, cnt_err, out_err, out_inst}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", in_ready, 1);
    monitor();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 64'd5);
    drain();
    chk("post_rst_addi", last_res, {2'd0, 32'h00500093});
    chk("post_rst_cnt", {cnt_ok, cnt_err}, {16'd1, 16'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The port clk SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 The input port in_valid SHALL be 1 bit wide: the request is valid.
REQ-005 The output port in_ready SHALL be 1 bit wide: the encoder accepts a request this cycle.
REQ-006 The input ports in_opcode[6:0], in_rd[4:0], in_funct3[2:0], in_rs1[4:0], in_rs2[4:0] and in_funct7[6:0] SHALL carry the instruction fields.
REQ-007 The input port in_imm SHALL be 64 bits wide: the signed immediate (byte offset for B and J).
REQ-008 The output port out_valid SHALL be 1 bit wide: the encoded result is valid.
REQ-009 The input port out_ready SHALL be 1 bit wide: the consumer accepts the result.
REQ-010 The output port out_inst SHALL be 32 bits wide: the encoded RV64 instruction word.
REQ-011 The output port out_err SHALL be 2 bits wide: 0 = OK, 1 = invalid opcode, 2 = immediate out of range, 3 = misaligned.
REQ-012 The output ports cnt_ok and cnt_err SHALL each be 16 bits wide: saturating counts of results delivered with and without error.

Function
REQ-013 The encoder SHALL classify the opcode as follows:
- I-type: 0000011, 0010011, 0011011, 0001111, 1110011, 1100111.
- S-type: 0100011.
- B-type: 1100011.
- U-type: 0110111, 0010111.
- J-type: 1101111.
- R-type: 0110011, 0111011.
- Any other opcode: invalid.
REQ-014 Stage 1 SHALL register the fields, the type and the error code; stage 2 SHALL register out_inst, out_err and out_valid.
REQ-015 Latency SHALL be 2 cycles from the input handshake to out_valid, with a throughput of 1 per cycle when out_ready is held high.
REQ-016 A handshake SHALL occur when valid and ready are both 1.
REQ-017 in_ready SHALL equal !s1_valid || s1_advance, where s1_advance = !out_valid || out_ready.
REQ-018 in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 While out_valid=1 and out_ready=0, out_inst and out_err SHALL hold stable and stage 1 SHALL hold its contents.
REQ-020 Results SHALL emerge in acceptance order; no request is lost or duplicated.
REQ-021 The range checks SHALL be:
- I and S: in_imm == sext(in_imm[11:0]).
- B: in_imm == sext(in_imm[12:0]).
- J: in_imm == sext(in_imm[20:0]).
- U: in_imm == sext(in_imm[31:0]) and in_imm[11:0] == 0.
REQ-022 The alignment check SHALL apply to B and J only: in_imm[0] SHALL be 0.
REQ-023 R-type SHALL ignore in_imm and perform no range or alignment check.
REQ-024 Error priority SHALL be invalid (1) > misaligned (3) > range (2).
REQ-025 The packing SHALL follow the standard RISC-V formats:
- R: funct7|rs2|rs1|f3|rd|op.
- I: imm[11:0]|rs1|f3|rd|op.
- S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
- B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
- U: imm[31:12]|rd|op.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-026 When out_err != 0, out_inst SHALL be 32'h0000_0000.
REQ-027 On each output handshake, cnt_ok SHALL increment if out_err == 0, otherwise cnt_err SHALL increment.
REQ-028 Each counter SHALL saturate at 16'hFFFF and never wrap.
REQ-029 A simultaneous input and output handshake SHALL advance both stages in the same cycle without a bubble.

Reset
REQ-030 When rst_n=0 (asynchronous), out_valid, stage-1 valid, out_inst, out_err, cnt_ok and cnt_err SHALL clear to 0.
REQ-031 When rst_n=0, in_ready SHALL be 0.
REQ-032 A reset asserted mid-operation SHALL discard in-flight requests with no output handshake.
REQ-033 in_ready SHALL be 1 on the first clock edge after rst_n deasserts.

Verification
REQ-034 ADDI: op 0010011, rd=1, f3=0, rs1=0, imm=64'hFFFF_FFFF_FFFF_FFFF -> out_inst 32'hFFF00093, out_err 0, out_valid 2 cycles after acceptance.
REQ-035 SW: op 0100011, f3=2, rs1=2, rs2=5, imm=8 -> 32'h00512423; JAL rd=1, imm=64'h800 -> 32'h001000EF.
REQ-036 Errors:
- LUI rd=5, imm=64'h1234_5000 -> 32'h123452B7.
- LUI imm=64'h1_0000_0000 -> out_err 2.
- BEQ imm=3 -> out_err 3, out_inst 0.
- op 7'h7F -> out_err 1.
REQ-037 Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts, out_inst stable, all 4 delivered in order once out_ready=1.
REQ-038 Counter saturation: preload or drive 65537 OK results -> cnt_ok holds 16'hFFFF and cnt_err is unchanged.
REQ-039 Reset mid-stream: rst_n pulses low with both stages full -> out_valid 0 immediately, no output handshake, counters 0, next request encoded correctly.
